psg_bus_interface: RTL

//  Upstream host-bus front end for the SN76489 PSG core. Samples an asynchronous
//  8-bit write bus (data, WE_n, CE_n) from the pins and synchronises it to clk.

---
 rtl/psg_bus_interface.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/psg_bus_interface.sv
// -----------------------------------------------------------------------------
// psg_bus_interface
//
// Host-bus front end for the SN76489 PSG core. The asynchronous 8-bit write
// bus (data, WE_n, CE_n) is brought into the clk domain through flip-flop
// synchronisers. Each completed write (WE_n rising while CE_n is low) is queued
// in a small FIFO. Queued bytes are replayed to the PSG register decoder as
// single-cycle strobes, at most one every DRAIN_INTERVAL clocks.
//
// Parameters
//   FIFO_DEPTH      queue depth in bytes (power of two, >= 2)
//   SYNC_STAGES     synchroniser depth on bus_we_n, bus_ce_n and bus_data
//   DRAIN_INTERVAL  minimum clk cycles between successive psg_wr pulses (>= 1)
//   WRITE_CYCLES    ready-low time per write when READY emulation is built in
//
// Build option
//   PSG_READY_EMU_EN  when defined, ready also drops for WRITE_CYCLES clocks
//                     after each host write, mimicking the chip's READY pin.
//                     When undefined, ready only reflects FIFO space.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   bus_data    in   [7:0] asynchronous host data byte (latch/data format)
//   bus_we_n    in   asynchronous write strobe, active low
//   bus_ce_n    in   asynchronous chip enable, active low
//   ready       out  registered: host may issue a write
//   psg_data    out  [7:0] byte to the PSG register decoder, valid with psg_wr
//   psg_wr      out  one-cycle write strobe to the PSG
//   fifo_level  out  number of queued bytes
//   overflow    out  sticky: a host write was dropped because the FIFO was full
//
// Handshake: the host side has no back-pressure beyond ready; a write that
// arrives while the FIFO is full and no byte leaves in the same cycle is
// dropped and flagged in overflow. The PSG side is push-only: psg_wr is a
// one-cycle strobe with psg_data valid in that same cycle, and the decoder
// must accept it unconditionally.
// -----------------------------------------------------------------------------
module psg_bus_interface #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DRAIN_INTERVAL = 16,
    parameter int WRITE_CYCLES   = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        bus_data,
    input  logic                              bus_we_n,
    input  logic                              bus_ce_n,
    output logic                              ready,
    output logic [7:0]                        psg_data,
    output logic                              psg_wr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(DRAIN_INTERVAL) + 1;
    localparam int BUSY_W  = $clog2(WRITE_CYCLES + 1);

    localparam logic [LEVEL_W-1:0] DEPTH_L      = LEVEL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   DRAIN_RELOAD = CNT_W'(DRAIN_INTERVAL - 1);

    // ------------------------------------------------------------------
    // Synchronisers. Strobes preset high so reset never fabricates an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] we_sync;
    logic [SYNC_STAGES-1:0] ce_sync;
    logic [7:0]             data_sync [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            we_sync <= '1;
            ce_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
        end else begin
            we_sync[0]   <= bus_we_n;
            ce_sync[0]   <= bus_ce_n;
            data_sync[0] <= bus_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                we_sync[i]   <= we_sync[i-1];
                ce_sync[i]   <= ce_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    logic       we_s;
    logic       ce_s;
    logic [7:0] data_s;

    assign we_s   = we_sync[SYNC_STAGES-1];
    assign ce_s   = ce_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Write capture. data_hold tracks the bus while the strobe is active,
    // so on the WE_n rise it holds the byte the host presented.
    // ------------------------------------------------------------------
    logic       we_s_q;
    logic       ce_s_q;
    logic [7:0] data_hold;
    logic       wr_event;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_s_q    <= 1'b1;
            ce_s_q    <= 1'b1;
            data_hold <= '0;
        end else begin
            we_s_q <= we_s;
            ce_s_q <= ce_s;
            if (!we_s && !ce_s) begin
                data_hold <= data_s;
            end
        end
    end

    // Rising WE_n with CE_n low in the cycle before the rise.
    assign wr_event = we_s && !we_s_q && !ce_s_q;

    // ------------------------------------------------------------------
    // FIFO and drain scheduler
    // ------------------------------------------------------------------
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_next;
    logic [CNT_W-1:0]   drain_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    always_comb begin
        fifo_empty = (level == '0);
        fifo_full  = (level == DEPTH_L);
        // An empty FIFO can still pop when a write lands this cycle: the
        // incoming byte is the head, so the strobe appears on the next cycle.
        pop        = (!fifo_empty || wr_event) && (drain_cnt == '0);
        push       = wr_event && (!fifo_full || pop);
        head       = fifo_empty ? data_hold : mem[rd_ptr];
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LEVEL_W'(1);
            2'b01:   level_next = level - LEVEL_W'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            drain_cnt <= '0;
            psg_wr    <= 1'b0;
            psg_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level  <= level_next;
            psg_wr <= pop;
            if (pop) begin
                psg_data <= head;
            end
            if (pop) begin
                drain_cnt <= DRAIN_RELOAD;
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
            if (wr_event && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign fifo_level = level;

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
    logic [BUSY_W-1:0] busy_next;

`ifdef PSG_READY_EMU_EN
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(WRITE_CYCLES);

    logic [BUSY_W-1:0] busy;
    logic              we_fall;

    // The busy window starts when the synchronised strobe goes active.
    assign we_fall = !we_s && we_s_q && !ce_s;

    always_comb begin
        busy_next = busy;
        if (we_fall) begin
            busy_next = BUSY_LOAD;
        end else if (busy != '0) begin
            busy_next = busy - BUSY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
`else
    // No chip-busy emulation: the busy term is permanently idle.
    assign busy_next = '0;
`endif

    // Computed from next-state values so ready lines up with fifo_level.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b1;
        end else begin
            ready <= (busy_next == '0) && (level_next < DEPTH_L);
        end
    end

endmodule
